// File: rtl/pc_panel_ctrl.sv
// pc_panel_ctrl: front-panel sequencer that owns the program counter.
// It debounces the push-buttons into single-cycle step, clear, run/stop
// and load commands, and auto-advances the PC in RUN mode until a
// breakpoint stops it.
// Ports:
//   clk, rst_n    clock and async active-low reset
//   pb            raw buttons, pressed = 0
//                 [1] load, [2] run/stop, [3] step, [4] clear, [0] unused
//   load_addr     PC value taken on a load command
//   bp_en/bp_addr breakpoint enable and address, checked on advances only
//   pc_out        current PC
//   pc_wrap       one-cycle pulse on an advance from all-ones to zero
//   step_pulse    one-cycle pulse on every advance
//   run_mode      high while in RUN
//   bp_hit        sticky; set when RUN stops on a breakpoint
module pc_panel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 12500000,
    parameter int PC_W            = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      pb,
    input  logic [PC_W-1:0] load_addr,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    output logic [PC_W-1:0] pc_out,
    output logic            pc_wrap,
    output logic            step_pulse,
    output logic            run_mode,
    output logic            bp_hit
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RC_W = $clog2(RUN_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RUN_DIV - 1);

    typedef enum logic {
        ST_STOP,
        ST_RUN
    } state_t;

    // ---------------- input path ----------------
    logic [4:0]           s1_q, s2_q;
    logic [4:0]           db_q, db_d;
    logic [4:0]           press_q, press_d;
    logic [4:0][DB_W-1:0] cnt_q, cnt_d;
    logic                 unused_pb0;

    // The counter only runs while a level change is pending; any sample
    // that agrees with the accepted level (a bounce back) restarts it.
    always_comb begin
        db_d    = db_q;
        press_d = '0;
        cnt_d   = '0;
        for (int i = 0; i < 5; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i]    = s2_q[i];
                    press_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '1;
            s2_q    <= '1;
            db_q    <= '1;
            cnt_q   <= '0;
            press_q <= '0;
        end else begin
            s1_q    <= pb;
            s2_q    <= s1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign unused_pb0 = press_q[0];

    // ---------------- sequencer ----------------
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [RC_W-1:0] rc_q, rc_d;
    logic            wrap_q, wrap_d;
    logic            step_q, step_d;
    logic            bp_q, bp_d;
    logic            ev_load, ev_run, ev_step, ev_clr;
    logic            tick, adv;

    assign ev_load = press_q[1];
    assign ev_run  = press_q[2];
    assign ev_step = press_q[3];
    assign ev_clr  = press_q[4];

    assign pc_inc = pc_q + PC_W'(1);
    assign tick   = (state_q == ST_RUN) && (rc_q == RC_LAST);
    // Manual steps only count in STOP; in RUN only the divider advances.
    assign adv    = (state_q == ST_RUN) ? tick : ev_step;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wrap_d  = 1'b0;
        step_d  = 1'b0;
        bp_d    = bp_q;
        rc_d    = rc_q;
        if (state_q == ST_RUN) begin
            rc_d = tick ? '0 : rc_q + RC_W'(1);
        end
        if (ev_clr) begin
            pc_d    = '0;
            state_d = ST_STOP;
        end else if (ev_load) begin
            pc_d = load_addr;
            if (state_q == ST_RUN) begin
                rc_d = '0;
            end
        end else if (adv) begin
            pc_d   = pc_inc;
            step_d = 1'b1;
            wrap_d = (pc_q == '1);
            if ((state_q == ST_RUN) && bp_en && (pc_inc == bp_addr)) begin
                state_d = ST_STOP;
                bp_d    = 1'b1;
            end
        end else if (ev_run) begin
            if (state_q == ST_STOP) begin
                state_d = ST_RUN;
                bp_d    = 1'b0;
                rc_d    = '0;
            end else begin
                state_d = ST_STOP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            pc_q    <= '0;
            rc_q    <= '0;
            wrap_q  <= 1'b0;
            step_q  <= 1'b0;
            bp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rc_q    <= rc_d;
            wrap_q  <= wrap_d;
            step_q  <= step_d;
            bp_q    <= bp_d;
        end
    end

    assign pc_out     = pc_q;
    assign pc_wrap    = wrap_q;
    assign step_pulse = step_q;
    assign run_mode   = (state_q == ST_RUN);
    assign bp_hit     = bp_q;

endmodule
